uart_bps_sched: RTL and testbench
=================================

UART_BPS_SCHED -- requirements
Module: uart_bps_sched

Interface
REQ-001 Parameter DEFAULT_BPS, 4'b1110, baud code loaded at reset (115200 baud at clk = 27 MHz).
REQ-002 Parameter IDLE_GUARD, 16, number of consecutive idle cycles required before a baud switch.
REQ-003 Parameter SETTLE_CYCLES, 2, cycles bps_sel is held before the divisor is captured (covers the registered divisor-table latency).
REQ-004 Port clk, input, 1, single 27 MHz clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous and active-high.
REQ-006 Port cfg_req, input, 1, level request to change baud; the requester holds it until cfg_ack.
REQ-007 Port cfg_bps, input, 4, requested baud code; valid while cfg_req=1.
REQ-008 Port cfg_ack, output, 1, one-cycle pulse: new baud is in effect.
REQ-009 Port tx_busy, input, 1, transmitter mid-frame.
REQ-010 Port rx_busy, input, 1, receiver mid-frame.
REQ-011 Port uart_hold, output, 1, forbids TX/RX from starting new frames.
REQ-012 Port bps_sel, output, 4, code driven to the divisor table.
REQ-013 Port bps_cnt_data, input, 16, divisor returned by the table; valid 1 cycle after bps_sel changes.
REQ-014 Port cur_bps, output, 4, code currently in effect.
REQ-015 Port baud_tick, output, 1, one-cycle pulse per bit period.
REQ-016 Port half_tick, output, 1, one-cycle pulse at mid-bit, for RX sampling.

Function
REQ-017 The FSM SHALL have states INIT, RUN, DRAIN, LOAD and ACK.
REQ-018 INIT: hold=1 and the tick counter is frozen for SETTLE_CYCLES cycles; the block then captures div_r from bps_cnt_data and enters RUN with no cfg_ack.
REQ-019 RUN: hold=0; cfg_req=1 with cfg_bps != cur_bps latches the new code and enters DRAIN.
REQ-020 RUN: cfg_req=1 with cfg_bps == cur_bps enters ACK directly; no hold, tick phase unchanged.
REQ-021 DRAIN: hold=1; a guard counter increments while tx_busy=0 and rx_busy=0, and clears to 0 on any busy cycle.
REQ-022 DRAIN: when the guard counter reaches IDLE_GUARD, the block drives bps_sel to the new code and enters LOAD.
REQ-023 DRAIN has no timeout; it waits indefinitely.
REQ-024 LOAD: hold=1 and the tick counter is frozen at 0 for SETTLE_CYCLES cycles; on the last LOAD cycle the block captures div_r and updates cur_bps.
REQ-025 ACK: cfg_ack=1 for exactly one cycle, hold=0, the tick counter restarts from 0, and the next state is RUN.
REQ-026 cfg_req is sampled only in RUN, so a request still high in the cycle after ACK is treated as a new request.
REQ-027 Tick counter: 16-bit, counts 0..div_r-1 then wraps to 0.
REQ-028 baud_tick=1 when count == div_r-1.
REQ-029 half_tick=1 when count == (div_r>>1)-1.
REQ-030 A captured divisor below 2 SHALL be clamped to 2.
REQ-031 In RUN and ACK the counter runs freely; it ticks whether or not the UART is busy.
REQ-032 In DRAIN the counter keeps running on the old div_r, so in-flight frames complete at the old baud.

Reset
REQ-033 On rst=1 the block SHALL enter INIT with bps_sel=cur_bps=DEFAULT_BPS, uart_hold=1, cfg_ack=0, baud_tick=0, half_tick=0, count=0, guard counter=0 and div_r=0.
REQ-034 Reset in any state, including mid-DRAIN or mid-LOAD, SHALL abandon the pending request without asserting cfg_ack.

Structure
REQ-035 Shared package uart_pkg SHALL hold the FSM state encoding and the named 4-bit baud code constants (BPS_600 .. BPS_230400).
REQ-036 The tick counter SHALL be a sub-module uart_baud_tick with inputs div, run and restart and outputs baud_tick and half_tick.

Verification
REQ-037 Reset released, table at DEFAULT_BPS returning 234 -> uart_hold=1 for 2 cycles, then baud_tick every 234 cycles and half_tick at count 116.
REQ-038 In RUN with UART idle, cfg_req with cfg_bps=4'b1111 (table returns 117) -> DRAIN for 16 cycles, LOAD for 2, cfg_ack, then baud_tick period 117 and cur_bps=4'b1111.
REQ-039 tx_busy=1 for 100 cycles at request, plus a 1-cycle rx_busy glitch at guard count 10 -> guard counter restarts, cfg_ack arrives 16 cycles after the last busy cycle plus 3, and ticks keep period 234 throughout DRAIN.
REQ-040 cfg_req with cfg_bps == cur_bps -> cfg_ack one cycle later, uart_hold never asserted, tick phase undisturbed.
REQ-041 rst asserted at guard count 8 in DRAIN -> no cfg_ack, cur_bps=DEFAULT_BPS, and the INIT sequence repeats.
REQ-042 Table returning 1 for the requested code -> div_r clamps to 2 and baud_tick pulses every 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud-rate scheduler: FSM state encoding,
// named baud codes and the divisor clamp used when a table value is captured.
package uart_pkg;

    // Scheduler phases
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_LOAD  = 3'd3,
        ST_ACK   = 3'd4
    } sched_state_e;

    // Baud codes as understood by the divisor table
    localparam logic [3:0] BPS_600    = 4'h3;
    localparam logic [3:0] BPS_1200   = 4'h4;
    localparam logic [3:0] BPS_2400   = 4'h5;
    localparam logic [3:0] BPS_4800   = 4'h6;
    localparam logic [3:0] BPS_9600   = 4'h7;
    localparam logic [3:0] BPS_14400  = 4'h8;
    localparam logic [3:0] BPS_19200  = 4'h9;
    localparam logic [3:0] BPS_28800  = 4'hA;
    localparam logic [3:0] BPS_38400  = 4'hB;
    localparam logic [3:0] BPS_57600  = 4'hC;
    localparam logic [3:0] BPS_76800  = 4'hD;
    localparam logic [3:0] BPS_115200 = 4'hE;
    localparam logic [3:0] BPS_230400 = 4'hF;

    localparam int          DIV_W   = 16;
    // A divisor of 0 or 1 would leave no room for a distinct half-bit tick
    localparam logic [15:0] DIV_MIN = 16'd2;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..div-1 and emits a full-bit and a mid-bit pulse.
// run=0 holds the count, restart forces it to 0 (and suppresses ticks).
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             restart,
    output logic             baud_tick,
    output logic             half_tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;
    logic [DIV_W-1:0] half_last;

    assign last      = div - 16'd1;
    assign half_last = (div >> 1) - 16'd1;

    // Free-running wrap counter; >= guards against a divisor that shrank under it
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            count <= '0;
        end else if (run) begin
            count <= (count >= last) ? '0 : count + 16'd1;
        end
    end

    assign baud_tick = run && !restart && (count == last);
    assign half_tick = run && !restart && (count == half_last);

endmodule

// File: rtl/uart_bps_sched.sv
// Baud-rate change scheduler: waits for the UART to go quiet, switches the
// divisor-table code, lets the table settle, captures the new divisor and
// acknowledges. Same-code requests are acknowledged without disturbing ticks.
module uart_bps_sched
    import uart_pkg::*;
#(
    parameter logic [3:0] DEFAULT_BPS   = BPS_115200,
    parameter int         IDLE_GUARD    = 16,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [3:0]  cfg_bps,
    output logic        cfg_ack,
    input  logic        tx_busy,
    input  logic        rx_busy,
    output logic        uart_hold,
    output logic [3:0]  bps_sel,
    input  logic [15:0] bps_cnt_data,
    output logic [3:0]  cur_bps,
    output logic        baud_tick,
    output logic        half_tick
);

    localparam int GW = (IDLE_GUARD    < 2) ? 1 : $clog2(IDLE_GUARD + 1);
    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LAST  = GW'(IDLE_GUARD - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    sched_state_e      state;
    logic [3:0]        new_bps;
    logic [15:0]       div_r;
    logic [GW-1:0]     guard;
    logic [SW-1:0]     settle;
    logic              tick_run;
    logic              tick_restart;

    // Scheduler FSM with registered hold/ack/code/divisor outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            uart_hold <= 1'b1;
            cfg_ack   <= 1'b0;
            bps_sel   <= DEFAULT_BPS;
            cur_bps   <= DEFAULT_BPS;
            new_bps   <= DEFAULT_BPS;
            div_r     <= '0;
            guard     <= '0;
            settle    <= '0;
        end else begin
            cfg_ack <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (settle == SETTLE_LAST) begin
                        settle    <= '0;
                        div_r     <= clamp_div(bps_cnt_data);
                        uart_hold <= 1'b0;
                        state     <= ST_RUN;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cfg_req) begin
                        if (cfg_bps != cur_bps) begin
                            new_bps   <= cfg_bps;
                            guard     <= '0;
                            uart_hold <= 1'b1;
                            state     <= ST_DRAIN;
                        end else begin
                            cfg_ack <= 1'b1;
                            state   <= ST_ACK;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Any busy cycle restarts the quiet window; the switch fires
                    // on the cycle the count would reach IDLE_GUARD.
                    if (tx_busy || rx_busy) begin
                        guard <= '0;
                    end else if (guard == GUARD_LAST) begin
                        guard   <= '0;
                        bps_sel <= new_bps;
                        settle  <= '0;
                        state   <= ST_LOAD;
                    end else begin
                        guard <= guard + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (settle == SETTLE_LAST) begin
                        settle    <= '0;
                        div_r     <= clamp_div(bps_cnt_data);
                        cur_bps   <= new_bps;
                        uart_hold <= 1'b0;
                        cfg_ack   <= 1'b1;
                        state     <= ST_ACK;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                ST_ACK: begin
                    state <= ST_RUN;
                end
                default: begin
                    uart_hold <= 1'b1;
                    state     <= ST_INIT;
                end
            endcase
        end
    end

    // Old divisor keeps ticking through DRAIN; LOAD parks the counter at 0
    // so the first post-switch bit period starts cleanly in ACK.
    assign tick_run     = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_ACK);
    assign tick_restart = (state == ST_LOAD);

    uart_baud_tick u_tick (
        .clk       (clk),
        .rst       (rst),
        .div       (div_r),
        .run       (tick_run),
        .restart   (tick_restart),
        .baud_tick (baud_tick),
        .half_tick (half_tick)
    );

endmodule

// File: tb/tb_uart_bps_sched.sv
// Bench for uart_bps_sched: phase-level model with arithmetic tick prediction,
// checked every cycle, plus hand-computed latency/period expectations.
module tb_uart_bps_sched;

    localparam int SETTLE = 2;
    localparam int GUARD  = 16;
    localparam logic [3:0] DEF = 4'hE;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [3:0]  cfg_bps;
    logic        cfg_ack;
    logic        tx_busy;
    logic        rx_busy;
    logic        uart_hold;
    logic [3:0]  bps_sel;
    logic [15:0] bps_cnt_data;
    logic [3:0]  cur_bps;
    logic        baud_tick;
    logic        half_tick;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    uart_bps_sched #(
        .DEFAULT_BPS   (DEF),
        .IDLE_GUARD    (GUARD),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_req      (cfg_req),
        .cfg_bps      (cfg_bps),
        .cfg_ack      (cfg_ack),
        .tx_busy      (tx_busy),
        .rx_busy      (rx_busy),
        .uart_hold    (uart_hold),
        .bps_sel      (bps_sel),
        .bps_cnt_data (bps_cnt_data),
        .cur_bps      (cur_bps),
        .baud_tick    (baud_tick),
        .half_tick    (half_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] tbl(input logic [3:0] c);
        case (c)
            4'hE:    return 16'd234;
            4'hF:    return 16'd117;
            4'hC:    return 16'd469;
            4'h3:    return 16'd1;
            default: return 16'd100;
        endcase
    endfunction

    // Divisor table with one cycle of latency
    always @(posedge clk) bps_cnt_data <= tbl(bps_sel);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- model ----------------
    localparam int M_INIT = 0, M_RUN = 1, M_DRAIN = 2, M_LOAD = 3, M_ACK = 4;
    int         m_mode  = M_INIT;
    int         m_left  = SETTLE;
    int         m_phase = 0;
    int         m_div   = 0;
    int         m_idle  = 0;
    bit         m_valid = 1'b0;
    logic [3:0] m_cur   = DEF;
    logic [3:0] m_sel   = DEF;
    logic [3:0] m_pend  = DEF;

    // monitor bookkeeping
    int hold_total    = 0;
    int ack_total     = 0;
    int last_ack_cyc  = -1;
    int last_baud_cyc = -1;
    int prev_baud_cyc = -1;
    int last_half_cyc = -1;

    function automatic int clampd(input logic [15:0] d);
        return (d < 16'd2) ? 2 : int'(d);
    endfunction

    always @(negedge clk) begin
        bit run;
        bit eb;
        bit eh;
        if (m_valid) begin
            run = (m_mode == M_RUN) || (m_mode == M_DRAIN) || (m_mode == M_ACK);
            eb  = run && ((m_phase % m_div) == m_div - 1);
            eh  = run && ((m_phase % m_div) == m_div / 2 - 1);
            chk("hold",      uart_hold, (m_mode == M_INIT || m_mode == M_DRAIN || m_mode == M_LOAD));
            chk("ack",       cfg_ack,   (m_mode == M_ACK));
            chk("bps_sel",   bps_sel,   m_sel);
            chk("cur_bps",   cur_bps,   m_cur);
            chk("baud_tick", baud_tick, eb);
            chk("half_tick", half_tick, eh);
        end
        if (uart_hold === 1'b1) hold_total++;
        if (cfg_ack === 1'b1) begin ack_total++; last_ack_cyc = cyc; end
        if (baud_tick === 1'b1) begin prev_baud_cyc = last_baud_cyc; last_baud_cyc = cyc; end
        if (half_tick === 1'b1) last_half_cyc = cyc;
        // advance model to the next cycle using this cycle's inputs
        if (rst) begin
            m_mode = M_INIT; m_left = SETTLE; m_phase = 0; m_div = 0;
            m_cur = DEF; m_sel = DEF; m_valid = 1'b1;
        end else begin
            case (m_mode)
                M_INIT: begin
                    m_left--;
                    if (m_left == 0) begin m_div = clampd(tbl(m_sel)); m_mode = M_RUN; end
                end
                M_RUN: begin
                    m_phase++;
                    if (cfg_req) begin
                        if (cfg_bps != m_cur) begin m_pend = cfg_bps; m_idle = 0; m_mode = M_DRAIN; end
                        else m_mode = M_ACK;
                    end
                end
                M_DRAIN: begin
                    m_phase++;
                    m_idle = (tx_busy || rx_busy) ? 0 : m_idle + 1;
                    if (m_idle == GUARD) begin
                        m_sel = m_pend; m_phase = 0; m_left = SETTLE; m_mode = M_LOAD;
                    end
                end
                M_LOAD: begin
                    m_left--;
                    if (m_left == 0) begin m_div = clampd(tbl(m_pend)); m_cur = m_pend; m_mode = M_ACK; end
                end
                default: begin
                    m_phase++;
                    m_mode = M_RUN;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int bound, output int at);
        int base;
        base = ack_total;
        at   = -1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (ack_total != base) begin at = last_ack_cyc; break; end
        end
        if (at < 0) begin
            n_checks++; n_err++;
            $display("FAIL ack_timeout at cycle %0d: got no ack, expected one within %0d cycles", cyc, bound);
        end
        cfg_req = 1'b0;
    endtask

    initial begin
        int rel, r, at, h0, a0, lb, t0;
        rst = 1'b1; cfg_req = 1'b0; cfg_bps = DEF; tx_busy = 1'b0; rx_busy = 1'b0;
        step(4);
        chk("rst_hold",  uart_hold, 1);
        chk("rst_ack",   cfg_ack,   0);
        chk("rst_cur",   cur_bps,   14);
        chk("rst_sel",   bps_sel,   14);
        chk("rst_baud",  baud_tick, 0);
        chk("rst_half",  half_tick, 0);

        // power-up: 2 hold cycles then 234-cycle bit period, half tick at count 116
        rst = 1'b0; rel = cyc; h0 = hold_total;
        step(240);
        chk("init_hold_cycles", hold_total - h0, 2);
        chk("first_baud_ofs",   last_baud_cyc - rel, 235);
        chk("first_half_ofs",   last_half_cyc - rel, 118);
        step(234);
        chk("period_234", last_baud_cyc - prev_baud_cyc, 234);
        step(200);

        // busy during request, one rx glitch at guard 10
        a0 = ack_total; h0 = hold_total; r = cyc;
        cfg_req = 1'b1; cfg_bps = 4'hC; tx_busy = 1'b1;
        step(100); tx_busy = 1'b0;
        step(10);  rx_busy = 1'b1; lb = cyc;
        chk("drain_old_grid", (last_baud_cyc - rel - 235) % 234, 0);
        chk("drain_tick_seen", (last_baud_cyc > r), 1);
        step(1);   rx_busy = 1'b0;
        wait_ack(60, at);
        chk("busy_ack_lat",     at - lb, 19);
        chk("busy_hold_cycles", hold_total - h0, 128);
        chk("busy_ack_count",   ack_total - a0, 1);
        chk("busy_cur",         cur_bps, 12);

        // idle switch to 230400
        h0 = hold_total; r = cyc;
        cfg_req = 1'b1; cfg_bps = 4'hF;
        wait_ack(60, at);
        chk("sw_ack_lat",     at - r, 19);
        chk("sw_hold_cycles", hold_total - h0, 18);
        step(240);
        chk("sw_period_117", last_baud_cyc - prev_baud_cyc, 117);
        chk("sw_new_grid",   last_baud_cyc - at, 233);
        chk("sw_cur",        cur_bps, 15);

        // same-code request: immediate ack, no hold, phase kept
        t0 = last_baud_cyc; h0 = hold_total; r = cyc;
        cfg_req = 1'b1; cfg_bps = 4'hF;
        wait_ack(10, at);
        chk("same_ack_lat",  at - r, 1);
        chk("same_no_hold",  hold_total - h0, 0);
        step(300);
        chk("same_phase",    (last_baud_cyc - t0) % 117, 0);
        chk("same_tick_after", (last_baud_cyc > at), 1);

        // reset in the middle of DRAIN at guard count 8
        a0 = ack_total; r = cyc;
        cfg_req = 1'b1; cfg_bps = 4'hC;
        step(9);
        rst = 1'b1; cfg_req = 1'b0;
        step(3);
        rst = 1'b0; rel = cyc; h0 = hold_total;
        step(240);
        chk("abort_no_ack",      ack_total - a0, 0);
        chk("abort_hold_cycles", hold_total - h0, 2);
        chk("abort_cur",         cur_bps, 14);
        chk("abort_sel",         bps_sel, 14);
        chk("abort_first_baud",  last_baud_cyc - rel, 235);

        // table returns 1: divisor clamps to 2
        r = cyc;
        cfg_req = 1'b1; cfg_bps = 4'h3;
        wait_ack(60, at);
        chk("clamp_ack_lat", at - r, 19);
        step(10);
        chk("clamp_period", last_baud_cyc - prev_baud_cyc, 2);
        chk("clamp_half",   (last_half_cyc >= last_baud_cyc - 1), 1);
        chk("clamp_cur",    cur_bps, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog at cycle %0d: got no end, expected finish", cyc);
        $fatal(1);
    end

endmodule
